// File: rtl/hid_matrix_kbd.sv
// hid_matrix_kbd
//   Keyboard front end for the EP1 interrupt endpoint. Scans a ROWS x COLS
//   key matrix, debounces whole frames, maps pressed keys through an external
//   synchronous keymap ROM into a boot-protocol HID report (ErrorRollOver on
//   overflow) and copies the report into the EP1 buffer on each host poll.
// Ports
//   clk        system clock
//   rst        synchronous active-high reset
//   row        one-hot row drive (registered)
//   line       sampled column lines, 1 = pressed
//   mod_in     modifier byte, copied into report byte 0
//   map_addr   keymap ROM address, key index r*COLS+c (registered)
//   map_code   keymap ROM data, valid 1 clk after map_addr, 0 = unmapped
//   ep1wrdata  EP1 buffer write data (registered)
//   ep1wraddr  EP1 buffer write address (registered)
//   ep1wr      EP1 buffer write strobe, one byte per high cycle (registered)
//   ep1txd     toggles each time the host has taken the buffered report
//   ep1tx      high while the EP1 buffer holds a report not yet sent
module hid_matrix_kbd #(
   parameter int ROWS       = 4,
   parameter int COLS       = 4,
   parameter int SCAN_DIV   = 65536,
   parameter int DEBOUNCE   = 4,
   parameter int REPORT_LEN = 8,
   localparam int N  = ROWS * COLS,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic            clk,
   input  logic            rst,
   output logic [ROWS-1:0] row,
   input  logic [COLS-1:0] line,
   input  logic [7:0]      mod_in,
   output logic [IW-1:0]   map_addr,
   input  logic [7:0]      map_code,
   output logic [7:0]      ep1wrdata,
   output logic [5:0]      ep1wraddr,
   output logic            ep1wr,
   input  logic            ep1txd,
   output logic            ep1tx
);

   localparam int KEYS = REPORT_LEN - 2;
   localparam int DW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int RB   = 8 * REPORT_LEN;

   typedef enum logic [1:0] {B_IDLE, B_SCAN, B_DONE} bstate_t;
   typedef enum logic       {T_IDLE, T_WRITE}        tstate_t;

   // scanner
   logic [DW-1:0] div_r;
   logic [3:0]    rix_r;
   logic [3:0]    rix_nxt_s;
   logic [N-1:0]  frame_r, prev_r, deb_r, frame_s;
   logic [3:0]    cnt_r, cnt_nxt_s;
   logic          div_last_s;

   // report builder
   bstate_t       b_state_r, b_state_s;
   logic [N-1:0]  snap_r;
   logic [7:0]    mod_r;
   logic [RB-1:0] work_r, report_s, staged_r;
   logic [8:0]    ptr_r, c_r;
   logic          vld_r;
   logic [IW-1:0] pidx_r;
   logic          trig_s, copy_s;

   // EP1 transmitter
   tstate_t       t_state_r, t_state_s;
   logic [RB-1:0] sent_r;
   logic          pend_r, txd_old_r, tog_s, take_s;
   logic [6:0]    wcnt_r;
   logic [7:0]    wbyte_s;

   assign div_last_s = (div_r == DW'(SCAN_DIV - 1));

   // Frame with the active row's lines merged in, next row index, next debounce count
   always_comb begin
      frame_s = frame_r;
      for (int r = 0; r < ROWS; r++) begin
         if (rix_r == 4'(r)) frame_s[r*COLS +: COLS] = line;
         else                frame_s[r*COLS +: COLS] = frame_r[r*COLS +: COLS];
      end
      if (rix_r == 4'(ROWS - 1)) rix_nxt_s = 4'd0;
      else                       rix_nxt_s = rix_r + 4'd1;
      if (cnt_r == 4'(DEBOUNCE)) cnt_nxt_s = cnt_r;
      else                       cnt_nxt_s = cnt_r + 4'd1;
   end

   // Row scanning, frame capture and whole-frame debounce
   always_ff @(posedge clk) begin
      if (rst) begin
         div_r   <= '0;
         rix_r   <= 4'd0;
         row     <= ROWS'(1'b1);
         frame_r <= '0;
         prev_r  <= '0;
         deb_r   <= '0;
         cnt_r   <= 4'd0;
      end else if (div_last_s) begin
         div_r   <= '0;
         frame_r <= frame_s;
         rix_r   <= rix_nxt_s;
         row     <= ROWS'(1'b1) << rix_nxt_s;
         if (rix_r == 4'(ROWS - 1)) begin
            if (frame_s == prev_r) begin
               cnt_r <= cnt_nxt_s;
               if ((cnt_nxt_s == 4'(DEBOUNCE)) && (frame_s != deb_r)) deb_r <= frame_s;
            end else begin
               cnt_r <= 4'd0;
            end
            prev_r <= frame_s;
         end
      end else begin
         div_r <= div_r + DW'(1);
      end
   end

   // A rebuild is owed whenever the matrix or modifiers differ from the last build input,
   // so changes landing mid-build are picked up once the builder returns to idle.
   assign trig_s = (deb_r != snap_r) || (mod_in != mod_r);
   assign copy_s = (b_state_r == B_DONE) && (t_state_r == T_IDLE);

   // Final report: all key slots become ErrorRollOver once more keys than slots are mapped
   always_comb begin
      report_s = work_r;
      for (int k = 0; k < KEYS; k++) begin
         if (ptr_r > 9'(KEYS)) report_s[8*(k+2) +: 8] = 8'h01;
         else                  report_s[8*(k+2) +: 8] = work_r[8*(k+2) +: 8];
      end
   end

   // Builder state register
   always_ff @(posedge clk) begin
      if (rst) b_state_r <= B_IDLE;
      else     b_state_r <= b_state_s;
   end

   // Builder next state
   always_comb begin
      b_state_s = b_state_r;
      case (b_state_r)
         B_IDLE:  if (trig_s) b_state_s = B_SCAN; else b_state_s = B_IDLE;
         B_SCAN:  if (c_r == 9'(N)) b_state_s = B_DONE; else b_state_s = B_SCAN;
         B_DONE:  if (t_state_r == T_IDLE) b_state_s = B_IDLE; else b_state_s = B_DONE;
         default: b_state_s = B_IDLE;
      endcase
   end

   // Builder datapath: ROM address is issued one index ahead of the code being consumed
   always_ff @(posedge clk) begin
      if (rst) begin
         snap_r   <= '0;
         mod_r    <= 8'h00;
         work_r   <= '0;
         ptr_r    <= 9'd0;
         map_addr <= '0;
         c_r      <= 9'd0;
         vld_r    <= 1'b0;
         pidx_r   <= '0;
         staged_r <= '0;
      end else begin
         case (b_state_r)
            B_IDLE: begin
               if (trig_s) begin
                  snap_r   <= deb_r;
                  mod_r    <= mod_in;
                  work_r   <= {{(RB-8){1'b0}}, mod_in};
                  ptr_r    <= 9'd0;
                  map_addr <= '0;
                  c_r      <= 9'd0;
                  vld_r    <= 1'b0;
               end
            end
            B_SCAN: begin
               vld_r  <= (c_r < 9'(N));
               pidx_r <= map_addr;
               c_r    <= c_r + 9'd1;
               if (map_addr != IW'(N - 1)) map_addr <= map_addr + IW'(1);
               if (vld_r && snap_r[pidx_r] && (map_code != 8'h00)) begin
                  for (int k = 0; k < KEYS; k++) begin
                     if (ptr_r == 9'(k)) work_r[8*(k+2) +: 8] <= map_code;
                  end
                  ptr_r <= ptr_r + 9'd1;
               end
            end
            B_DONE: begin
               if (t_state_r == T_IDLE) staged_r <= report_s;
            end
            default: ;
         endcase
      end
   end

   assign tog_s  = (ep1txd != txd_old_r);
   assign take_s = (t_state_r == T_IDLE) && tog_s && pend_r && (staged_r != sent_r);

   // Byte of the sent report selected by the write counter
   always_comb begin
      wbyte_s = 8'h00;
      for (int k = 0; k < REPORT_LEN; k++) begin
         if (wcnt_r == 7'(k)) wbyte_s = sent_r[8*k +: 8];
         else                 wbyte_s = wbyte_s;
      end
   end

   // Transmitter state register
   always_ff @(posedge clk) begin
      if (rst) t_state_r <= T_IDLE;
      else     t_state_r <= t_state_s;
   end

   // Transmitter next state
   always_comb begin
      t_state_s = t_state_r;
      case (t_state_r)
         T_IDLE:  if (take_s) t_state_s = T_WRITE; else t_state_s = T_IDLE;
         T_WRITE: if (wcnt_r == 7'(REPORT_LEN)) t_state_s = T_IDLE; else t_state_s = T_WRITE;
         default: t_state_s = T_IDLE;
      endcase
   end

   // Transmitter datapath; byte 0 goes out on the detection edge, so only idle sees toggles
   always_ff @(posedge clk) begin
      if (rst) begin
         ep1wr     <= 1'b0;
         ep1wraddr <= 6'd0;
         ep1wrdata <= 8'h00;
         ep1tx     <= 1'b0;
         sent_r    <= '0;
         pend_r    <= 1'b0;
         txd_old_r <= ep1txd;
         wcnt_r    <= 7'd0;
      end else begin
         case (t_state_r)
            T_IDLE: begin
               ep1wr <= 1'b0;
               if (tog_s) begin
                  txd_old_r <= ep1txd;
                  if (take_s) begin
                     sent_r    <= staged_r;
                     ep1tx     <= 1'b1;
                     ep1wr     <= 1'b1;
                     ep1wraddr <= 6'd0;
                     ep1wrdata <= staged_r[7:0];
                     wcnt_r    <= 7'd1;
                  end else begin
                     ep1tx <= 1'b0;
                  end
               end
            end
            T_WRITE: begin
               if (wcnt_r < 7'(REPORT_LEN)) begin
                  ep1wr     <= 1'b1;
                  ep1wraddr <= wcnt_r[5:0];
                  ep1wrdata <= wbyte_s;
                  wcnt_r    <= wcnt_r + 7'd1;
               end else begin
                  ep1wr <= 1'b0;
               end
            end
            default: ep1wr <= 1'b0;
         endcase
         // A freshly copied report stays pending even if the host took the previous one this cycle
         if (copy_s)                              pend_r <= 1'b1;
         else if (tog_s && (t_state_r == T_IDLE)) pend_r <= 1'b0;
      end
   end

endmodule

// File: tb/tb_hid_matrix_kbd.sv
// tb_hid_matrix_kbd
//   Directed bench for hid_matrix_kbd: 4x4 matrix, short scan divider, keymap
//   ROM model, EP1 write capture and hand-computed expected reports.
module tb_hid_matrix_kbd;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] row;
   logic [3:0] line;
   logic [7:0] mod_in;
   logic [3:0] map_addr;
   logic [7:0] map_code;
   logic [7:0] ep1wrdata;
   logic [5:0] ep1wraddr;
   logic       ep1wr;
   logic       ep1txd;
   logic       ep1tx;

   logic [15:0] keys;
   logic [7:0]  rom [16];
   logic [7:0]  cap [8];
   int          wr_cnt = 0;
   int          n_chk  = 0;
   int          n_pass = 0;

   hid_matrix_kbd #(.ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE(4), .REPORT_LEN(8)) dut (
      .clk(clk), .rst(rst), .row(row), .line(line), .mod_in(mod_in),
      .map_addr(map_addr), .map_code(map_code), .ep1wrdata(ep1wrdata),
      .ep1wraddr(ep1wraddr), .ep1wr(ep1wr), .ep1txd(ep1txd), .ep1tx(ep1tx)
   );

   always #5 clk = ~clk;

   // Key matrix model: lines of every driven row
   always_comb begin
      line = 4'h0;
      for (int r = 0; r < 4; r++) begin
         if (row[r]) line = line | keys[r*4 +: 4];
      end
   end

   // Synchronous keymap ROM: index i -> 0x10+i, index 6 -> 0x1E, index 15 unmapped
   always_ff @(posedge clk) map_code <= rom[map_addr];

   // EP1 buffer capture
   always @(negedge clk) begin
      if (ep1wr) begin
         cap[ep1wraddr[2:0]] = ep1wrdata;
         wr_cnt = wr_cnt + 1;
      end
   end

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic toggle_txd();
      tick();
      ep1txd = ~ep1txd;
      repeat (14) tick();
   endtask

   // Toggle the poll line and compare the written report (or absence of writes)
   task automatic poll_check(input string tag, input logic [63:0] exp, input int exp_n, input logic exp_tx);
      int base;
      base = wr_cnt;
      toggle_txd();
      check_val({tag, "_nwr"}, 64'(wr_cnt - base), 64'(exp_n));
      check_val({tag, "_tx"}, 64'(ep1tx), 64'(exp_tx));
      if (exp_n == 8) begin
         for (int k = 0; k < 8; k++)
            check_val($sformatf("%s_b%0d", tag, k), 64'(cap[k]), 64'(exp[8*k +: 8]));
      end
   endtask

   initial begin
      int  base;
      bit  done;
      bit  tog2;
      for (int i = 0; i < 16; i++) rom[i] = 8'(8'h10 + i);
      rom[6]  = 8'h1E;
      rom[15] = 8'h00;
      keys   = 16'h0000;
      mod_in = 8'h00;
      ep1txd = 1'b1;
      rst    = 1'b1;
      repeat (3) tick();
      check_val("rst_row", 64'(row), 64'h1);
      check_val("rst_ep1tx", 64'(ep1tx), 64'h0);
      check_val("rst_ep1wr", 64'(ep1wr), 64'h0);
      check_val("rst_waddr", 64'(ep1wraddr), 64'h0);
      check_val("rst_wdata", 64'(ep1wrdata), 64'h0);
      check_val("rst_maddr", 64'(map_addr), 64'h0);
      rst = 1'b0;
      repeat (20) tick();
      poll_check("nokeys", 64'h0, 0, 1'b0);

      // single key (1,2) -> ROM[6]
      keys = 16'h0040;
      repeat (200) tick();
      poll_check("key12", 64'h00000000001E0000, 8, 1'b1);

      // release, then bounce on alternate frames: no commit
      keys = 16'h0000;
      repeat (200) tick();
      poll_check("release", 64'h0, 8, 1'b1);
      for (int f = 0; f < 10; f++) begin
         keys = keys ^ 16'h0040;
         repeat (16) tick();
      end
      repeat (100) tick();
      poll_check("bounce", 64'h0, 0, 1'b0);
      keys = 16'h0040;
      repeat (200) tick();
      poll_check("stable", 64'h00000000001E0000, 8, 1'b1);

      // seven mapped keys plus one unmapped -> rollover, then six in index order
      keys = 16'hD265;
      repeat (200) tick();
      poll_check("rollover", 64'h0101010101010000, 8, 1'b1);
      keys = 16'h9265;
      repeat (200) tick();
      poll_check("six", 64'h1C191E1512100000, 8, 1'b1);

      // modifier only, then no change
      keys   = 16'h0000;
      mod_in = 8'h02;
      repeat (200) tick();
      poll_check("mod", 64'h0000000000000002, 8, 1'b1);
      poll_check("nochange", 64'h0, 0, 1'b0);

      // toggle during write, reset at write 3
      keys = 16'h0040;
      repeat (200) tick();
      base = wr_cnt;
      done = 1'b0;
      tog2 = 1'b0;
      tick();
      ep1txd = ~ep1txd;
      for (int i = 0; i < 30 && !done; i++) begin
         tick();
         if ((wr_cnt - base == 1) && !tog2) begin
            ep1txd = ~ep1txd;
            tog2 = 1'b1;
         end
         if (wr_cnt - base == 3) done = 1'b1;
      end
      check_val("abort_reached3", 64'(done), 64'h1);
      rst = 1'b1;
      tick();
      check_val("abort_ep1wr", 64'(ep1wr), 64'h0);
      check_val("abort_ep1tx", 64'(ep1tx), 64'h0);
      check_val("abort_row", 64'(row), 64'h1);
      tick();
      rst = 1'b0;
      repeat (40) tick();
      check_val("abort_nwr", 64'(wr_cnt - base), 64'h3);
      check_val("abort_tx_idle", 64'(ep1tx), 64'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
